// File: rtl/axis_sa_out_transpose.sv
// Ping-pong transpose buffer: captures column-major result tiles from the
// systolic array and re-emits them row-major on an AXI-stream master port.
module axis_sa_out_transpose #(
    parameter int R  = 4,
    parameter int C  = 8,
    parameter int WY = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_last,
    input  logic [R*WY-1:0] s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic [C*WY-1:0] m_data,
    output logic            err_len
);

    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    logic [WY-1:0]       mem [2][R][C];
    logic [1:0]          full;
    logic [1:0][C-1:0]   mask;
    logic                wr_bank;
    logic [CW-1:0]       wr_col;
    logic                rd_bank;
    logic [RW-1:0]       rd_row;

    logic wr_fire, rd_fire, wr_last_col, wr_close, rd_last_row;

    assign s_ready     = rstn && !full[wr_bank];
    assign m_valid     = full[rd_bank];
    assign wr_fire     = s_valid && s_ready;
    assign rd_fire     = m_valid && m_ready;
    assign wr_last_col = (wr_col == CW'(C - 1));
    assign wr_close    = s_last || wr_last_col;
    assign rd_last_row = (rd_row == RW'(R - 1));
    assign m_last      = m_valid && rd_last_row;

    // Write and read always touch different banks: a write needs an empty
    // bank and a read needs a full one, so both updates can land together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full    <= '0;
            mask    <= '0;
            wr_bank <= 1'b0;
            wr_col  <= '0;
            rd_bank <= 1'b0;
            rd_row  <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (wr_fire) begin
                mask[wr_bank][wr_col] <= 1'b1;
                if (wr_close) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_col        <= '0;
                    err_len       <= s_last ^ wr_last_col;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_last_row) begin
                    full[rd_bank] <= 1'b0;
                    mask[rd_bank] <= '0;
                    rd_bank       <= ~rd_bank;
                    rd_row        <= '0;
                end else begin
                    rd_row <= rd_row + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned r = 0; r < R; r++) begin
                mem[wr_bank][r][wr_col] <= s_data[r*WY +: WY];
            end
        end
    end

    // Columns never written in the current packet read as zero.
    always_comb begin
        m_data = '0;
        for (int unsigned c = 0; c < C; c++) begin
            if (mask[rd_bank][c]) begin
                m_data[c*WY +: WY] = mem[rd_bank][rd_row][c];
            end
        end
    end

endmodule

// File: tb/tb_axis_sa_out_transpose.sv
// Scoreboard bench for axis_sa_out_transpose: a tile-level reference model
// queues expected rows; a negedge monitor compares every output handshake.
module tb_axis_sa_out_transpose;

    localparam int R  = 4;
    localparam int C  = 8;
    localparam int WY = 16;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            s_valid, s_ready, s_last;
    logic [R*WY-1:0] s_data;
    logic            m_valid, m_ready, m_last;
    logic [C*WY-1:0] m_data;
    logic            err_len;

    always #5 clk = ~clk;

    axis_sa_out_transpose #(.R(R), .C(C), .WY(WY)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data),
        .err_len(err_len)
    );

    typedef struct {
        logic [C*WY-1:0] data;
        logic            last;
    } row_t;

    row_t            q[$];
    int              total = 0;
    int              bad = 0;
    int              err_seen = 0;
    int              stall_cycles = 0;
    logic            rand_mr = 1'b0;

    // reference model state: one tile being assembled, column-major
    logic [WY-1:0]   tile_m [R][C];
    logic [C-1:0]    tmask = '0;
    int              mc = 0;
    logic            exp_err = 1'b0;
    logic            prev_stall = 1'b0;
    logic [C*WY-1:0] prev_data;
    logic            prev_last;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        row_t e;
        int   tiles;
        if (!rstn) begin
            q.delete();
            tmask      = '0;
            mc         = 0;
            exp_err    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            tiles = (q.size() + R - 1) / R;
            chk("m_valid", 128'(m_valid), 128'(q.size() > 0));
            chk("s_ready", 128'(s_ready), 128'(tiles < 2));
            chk("err_len", 128'(err_len), 128'(exp_err));
            if (err_len) err_seen++;
            if (prev_stall) begin
                chk("stall_valid", 128'(m_valid), 128'(1));
                chk("stall_data", m_data, prev_data);
                chk("stall_last", 128'(m_last), 128'(prev_last));
            end
            exp_err = 1'b0;
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    chk("row_underflow", 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("row_data", m_data, e.data);
                    chk("row_last", 128'(m_last), 128'(e.last));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (s_valid && s_ready) begin
                for (int r = 0; r < R; r++) tile_m[r][mc] = s_data[r*WY +: WY];
                tmask[mc] = 1'b1;
                if (s_last || mc == C - 1) begin
                    exp_err = (s_last != (mc == C - 1));
                    for (int r = 0; r < R; r++) begin
                        e.data = '0;
                        for (int c = 0; c < C; c++)
                            if (tmask[c]) e.data[c*WY +: WY] = tile_m[r][c];
                        e.last = (r == R - 1);
                        q.push_back(e);
                    end
                    tmask = '0;
                    mc    = 0;
                end else begin
                    mc++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mr) m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_beat(input logic [R*WY-1:0] d, input logic l);
        logic rdy;
        int   n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 500) begin
                chk("send_timeout", 128'(0), 128'(1));
                break;
            end
        end
        stall_cycles += n;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    function automatic logic [R*WY-1:0] tile_beat(int t, int c);
        logic [R*WY-1:0] d;
        for (int r = 0; r < R; r++) d[r*WY +: WY] = WY'((t << 12) | (r << 8) | c);
        return d;
    endfunction

    task automatic send_tile(input int t, input int ncols, input logic with_last);
        for (int c = 0; c < ncols; c++)
            send_beat(tile_beat(t, c), with_last && (c == ncols - 1));
    endtask

    task automatic wait_empty();
        int n = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0 && !m_valid) break;
            n++;
            if (n > 2000) break;
        end
        chk("drain_empty", 128'(q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("reset_m_valid", 128'(m_valid), 128'(0));
        chk("reset_s_ready", 128'(s_ready), 128'(1));
        chk("reset_err_len", 128'(err_len), 128'(0));
        @(posedge clk);
        #1;

        // single tile
        e0 = err_seen;
        send_tile(0, C, 1'b1);
        wait_empty();
        chk("single_err_cnt", 128'(err_seen - e0), 128'(0));

        // three tiles back to back, no input bubbles
        stall_cycles = 0;
        for (int t = 1; t <= 3; t++) send_tile(t, C, 1'b1);
        chk("b2b_stalls", 128'(stall_cycles), 128'(0));
        wait_empty();

        // backpressure: two tiles fill both banks
        m_ready = 1'b0;
        stall_cycles = 0;
        send_tile(4, C, 1'b1);
        send_tile(5, C, 1'b1);
        chk("bp_stalls", 128'(stall_cycles), 128'(0));
        repeat (3) begin
            @(negedge clk);
            chk("bp_s_ready_low", 128'(s_ready), 128'(0));
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_empty();

        // early last, then an intact tile
        e0 = err_seen;
        send_tile(6, 5, 1'b1);
        send_tile(7, C, 1'b1);
        wait_empty();
        chk("early_err_cnt", 128'(err_seen - e0), 128'(1));

        // missing last, then an intact tile
        e0 = err_seen;
        send_tile(8, C, 1'b0);
        send_tile(9, C, 1'b1);
        wait_empty();
        chk("missing_err_cnt", 128'(err_seen - e0), 128'(1));

        // reset with one tile pending and a partial tile in capture
        m_ready = 1'b0;
        send_tile(10, C, 1'b1);
        send_tile(11, 3, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        rstn = 1'b1;
        m_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 128'(m_valid), 128'(0));
        end
        @(posedge clk);
        #1;
        send_tile(12, C, 1'b1);
        wait_empty();

        // randomized data, lengths, gaps and backpressure
        rand_mr = 1'b1;
        for (int t = 0; t < 12; t++) begin
            int kind = $urandom_range(0, 9);
            int ncols = (kind == 8) ? int'($urandom_range(1, C - 1)) : C;
            logic wl = (kind != 9);
            for (int c = 0; c < ncols; c++) begin
                logic [R*WY-1:0] d;
                for (int r = 0; r < R; r++) d[r*WY +: WY] = WY'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_beat(d, wl && (c == ncols - 1));
            end
        end
        rand_mr = 1'b0;
        @(posedge clk);
        #2 m_ready = 1'b1;
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
